// File: rtl/decode_operand_stage.sv
// ============================================================================
// decode_operand_stage : RV32I R/I-type decode and operand fetch feeding the ALU
// Revision: 1.0
// ============================================================================
`default_nettype none

module decode_operand_stage #(
  parameter int WORD_SIZE = 32,
  parameter int NUM_REGS  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [31:0]          instr,
  input  logic                 wb_en,
  input  logic [4:0]           wb_addr,
  input  logic [WORD_SIZE-1:0] wb_data,
  output logic                 ex_valid,
  input  logic                 ex_ready,
  output logic [6:0]           ex_funct7,
  output logic [2:0]           ex_funct3,
  output logic [WORD_SIZE-1:0] ex_source1,
  output logic [WORD_SIZE-1:0] ex_source2,
  output logic [4:0]           ex_rd,
  output logic                 illegal
);

  localparam logic [6:0] C_OP_R = 7'b0110011;
  localparam logic [6:0] C_OP_I = 7'b0010011;

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_e;

  state_e                 state_q;
  logic [6:0]             funct7_q;
  logic [2:0]             funct3_q;
  logic [WORD_SIZE-1:0]   source1_q;
  logic [WORD_SIZE-1:0]   source2_q;
  logic [4:0]             rd_q;
  logic                   illegal_q;
  logic [WORD_SIZE-1:0]   regs_q [NUM_REGS];

  logic [6:0]             opcode;
  logic [4:0]             rs1;
  logic [4:0]             rs2;
  logic                   is_r;
  logic                   is_i;
  logic                   accept;
  logic                   load;
  logic                   transfer;
  logic [6:0]             funct7_d;
  logic [WORD_SIZE-1:0]   source1_d;
  logic [WORD_SIZE-1:0]   source2_d;

  assign opcode   = instr[6:0];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign is_r     = (opcode == C_OP_R);
  assign is_i     = (opcode == C_OP_I);

  assign ex_valid    = (state_q == S_FULL);
  assign instr_ready = !ex_valid || ex_ready;
  assign accept      = instr_valid && instr_ready;
  assign load        = accept && (is_r || is_i);
  assign transfer    = ex_valid && ex_ready;

  // Same-cycle write-back wins over the stale register contents.
  function automatic logic [WORD_SIZE-1:0] read_operand(input logic [4:0] addr);
    if (addr == 5'd0)
      return '0;
    else if (wb_en && (wb_addr == addr))
      return wb_data;
    else
      return regs_q[addr];
  endfunction

  always_comb begin
    source1_d = read_operand(rs1);
    source2_d = '0;
    funct7_d  = 7'd0;
    if (is_r) begin
      source2_d = read_operand(rs2);
      funct7_d  = instr[31:25];
    end else begin
      source2_d = {{(WORD_SIZE-12){instr[31]}}, instr[31:20]};
      // Only shifts carry a meaningful funct7; addi must never become a subtract.
      if ((instr[14:12] == 3'b001) || (instr[14:12] == 3'b101))
        funct7_d = instr[31:25];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_EMPTY;
      funct7_q  <= '0;
      funct3_q  <= '0;
      source1_q <= '0;
      source2_q <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= accept && !(is_r || is_i);
      if (load) begin
        state_q   <= S_FULL;
        funct7_q  <= funct7_d;
        funct3_q  <= instr[14:12];
        source1_q <= source1_d;
        source2_q <= source2_d;
        rd_q      <= instr[11:7];
      end else if (transfer) begin
        state_q   <= S_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= '0;
    end else if (wb_en && (wb_addr != 5'd0)) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  assign ex_funct7  = funct7_q;
  assign ex_funct3  = funct3_q;
  assign ex_source1 = source1_q;
  assign ex_source2 = source2_q;
  assign ex_rd      = rd_q;
  assign illegal    = illegal_q;

endmodule

`default_nettype wire

// File: doc/decode_operand_stage.md
Name: decode_operand_stage

Overview:
- Decode/operand-fetch stage directly upstream of the ALU.
- Accepts 32-bit RV32I instructions and decodes R-type and I-type ALU ops.
- Reads operands from an internal 32-entry register file that has a write-back port.
- Presents funct7, funct3, source1 and source2 to the ALU through a one-entry valid/ready pipeline register.

Parameters:
- WORD_SIZE, 32, data width of registers and operands.
- NUM_REGS, 32, register count; fixed at 32, so register addresses are 5 bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- instr_valid  input  1  upstream has an instruction on instr.
- instr_ready  output  1  stage can accept an instruction this cycle.
- instr  input  32  RV32I instruction word.
- wb_en  input  1  register write-back enable.
- wb_addr  input  5  write-back destination register.
- wb_data  input  WORD_SIZE  write-back data.
- ex_valid  output  1  ALU-side outputs hold a valid operation.
- ex_ready  input  1  downstream consumes the operation this cycle.
- ex_funct7  output  7  funct7 for the ALU.
- ex_funct3  output  3  funct3 for the ALU.
- ex_source1  output  WORD_SIZE  operand 1 (rs1 value).
- ex_source2  output  WORD_SIZE  operand 2 (rs2 value or immediate).
- ex_rd  output  5  destination register, passed through for write-back.
- illegal  output  1  one-cycle pulse: an accepted instruction had an unsupported opcode.

Behaviour:
- **Reset** (rst_n low, asynchronous): ex_valid=0; ex_funct7, ex_funct3, ex_source1, ex_source2, ex_rd=0; illegal=0; all 32 registers=0. Reset mid-stall discards the held operation.
- **Handshake:**
  - instr_ready = !ex_valid || ex_ready (combinational).
  - Accept happens when instr_valid && instr_ready.
  - Transfer happens when ex_valid && ex_ready.
- **Output register:**
  - One entry, two states: EMPTY (ex_valid=0) and FULL (ex_valid=1).
  - EMPTY -> FULL on accept of a legal instruction.
  - FULL -> EMPTY on transfer with no legal accept in the same cycle.
  - FULL -> FULL on simultaneous transfer and legal accept: new data is loaded and there is no bubble.
  - While FULL and ex_ready=0, all ex_* outputs are held stable.
- **Latency:** 1 cycle from accept to ex_valid; back-to-back throughput is 1 per cycle.
- **Decode** (opcode = instr[6:0]):
  - 0110011 (R-type): ex_funct7=instr[31:25], ex_funct3=instr[14:12], ex_source1=R[rs1], ex_source2=R[rs2], ex_rd=instr[11:7].
  - 0010011 (I-type): ex_source2 = sign-extended instr[31:20] to WORD_SIZE.
  - I-type funct7: ex_funct7=0 when funct3=000, so addi never subtracts. ex_funct7=instr[31:25] when funct3 is 001 or 101 (shifts). ex_funct7=0 otherwise.
  - rs1=instr[19:15], rs2=instr[24:20].
  - Any other opcode: accepted (consumed) but not loaded. illegal=1 on the following cycle for one cycle. ex_valid then follows the transfer rule alone.
- **Register file:**
  - 32 x WORD_SIZE.
  - Write on the rising edge when wb_en=1 and wb_addr!=0; writes to x0 are ignored.
  - Reads of x0 always return 0.
- **Bypass:** if wb_en=1, wb_addr==rs (rs!=0) and the instruction is accepted in the same cycle, the operand is taken from wb_data rather than the stale register.
- **Captured operands:** a write-back after accept does not alter operands already in the output register.
- **Independence:** wb_en may be asserted in any cycle, including stall and reset-release cycles, independent of the handshake.

Test Plan:
- Reset then write x1=5, x2=3 via wb. Accept add x3,x1,x2 (0x002081B3), ex_ready=1 -> next cycle ex_valid=1, funct7=0, funct3=0, source1=5, source2=3, rd=3.
- Accept sub x3,x1,x2 (0x402081B3) while wb_en writes x2=7 in the same cycle -> source2=7 (bypass), funct7=0x20.
- Accept addi x4,x1,-1 (0xFFF08213) -> source2=0xFFFFFFFF, funct7=0.
- Hold ex_ready=0 with ex_valid=1 -> instr_ready=0 and outputs stable for 3 cycles, even with wb writing x1. Raise ex_ready together with a new instr_valid -> the new op loads the next cycle with no bubble.
- Write x0=0xDEAD. Then accept add x5,x0,x0 -> source1=source2=0.
- Accept opcode 0x7F -> illegal pulses for 1 cycle, ex_valid stays 0. Then assert rst_n=0 while FULL -> ex_valid drops immediately, without waiting for a clock edge.
